// File: rtl/junction_router.sv
// Registered 4-way junction: queues route tokens, holds one exit light for a programmable green time, then forwards the token.
// Optional per-exit handoff counters are enabled by defining JUNCTION_STATS_EN.
module junction_router #(
  parameter int unsigned PATH_W       = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned GREEN_CYCLES = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [1:0]           in_dir_i,
  input  logic [PATH_W-1:0]    in_path_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [1:0]           out_dir_o,
  output logic [PATH_W-1:0]    out_path_o,
  output logic                 nl_o,
  output logic                 wl_o,
  output logic                 el_o,
  output logic                 sl_o,
  output logic                 park_o,
  output logic                 busy_o,
  output logic [4*CNT_W-1:0]   exit_cnt_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = (GREEN_CYCLES > 1) ? $clog2(GREEN_CYCLES) : 1;
  localparam int unsigned TW = 2 + PATH_W;

  localparam logic [1:0] DIR_N = 2'b00;
  localparam logic [1:0] DIR_W = 2'b01;
  localparam logic [1:0] DIR_E = 2'b10;
  localparam logic [1:0] DIR_S = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PARK,
    S_GREEN,
    S_HANDOFF
  } state_e;

  // Right turn exits opposite to the left exit; straight exits opposite to arrival.
  function automatic logic [1:0] exit_side(input logic [1:0] dir, input logic [1:0] turn);
    logic [1:0] left;
    case (dir)
      DIR_N:   left = DIR_E;
      DIR_W:   left = DIR_N;
      DIR_E:   left = DIR_S;
      default: left = DIR_W;
    endcase
    case (turn)
      2'b10:   return ~dir;
      2'b11:   return ~left;
      default: return left;
    endcase
  endfunction

  // Input queue
  logic [TW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q;
  logic          push, pop;
  logic [TW-1:0] head;

  assign push    = in_valid_i && in_ready_q;
  assign head    = mem_q[rd_ptr_q];
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_dir_i, in_path_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      in_ready_q <= (count_d != CW'(FIFO_DEPTH));
    end
  end

  // Token FSM
  state_e            state_q, state_d;
  logic [1:0]        tok_dir_q, tok_dir_d;
  logic [PATH_W-1:0] tok_path_q, tok_path_d;
  logic [1:0]        exit_q, exit_d;
  logic [GW-1:0]     green_q, green_d;
  logic [1:0]        turn;
  logic [3:0]        lights_q, lights_d;
  logic              out_valid_q, out_valid_d;
  logic              park_q, park_d;
  logic              busy_q, busy_d;
  logic [1:0]        out_dir_q, out_dir_d;
  logic [PATH_W-1:0] out_path_q, out_path_d;

  assign turn = tok_path_q[PATH_W-1 -: 2];

  always_comb begin
    state_d    = state_q;
    tok_dir_d  = tok_dir_q;
    tok_path_d = tok_path_q;
    exit_d     = exit_q;
    green_d    = green_q;
    out_dir_d  = out_dir_q;
    out_path_d = out_path_q;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop                     = 1'b1;
          {tok_dir_d, tok_path_d} = head;
          state_d                 = S_LOAD;
        end
      end
      S_LOAD: begin
        if (turn == 2'b00) begin
          state_d = S_PARK;
        end else begin
          exit_d  = exit_side(tok_dir_q, turn);
          green_d = GW'(GREEN_CYCLES - 1);
          state_d = S_GREEN;
        end
      end
      S_PARK: state_d = S_IDLE;
      S_GREEN: begin
        if (green_q == '0) begin
          state_d    = S_HANDOFF;
          out_dir_d  = exit_q;
          out_path_d = {tok_path_q[PATH_W-3:0], 2'b00};
        end else begin
          green_d = green_q - GW'(1);
        end
      end
      S_HANDOFF: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs reflect the state being entered so they are registered yet cycle-aligned.
    lights_d    = (state_d == S_GREEN || state_d == S_HANDOFF) ? (4'b0001 << exit_d) : 4'b0000;
    out_valid_d = (state_d == S_HANDOFF);
    park_d      = (state_d == S_PARK);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tok_dir_q   <= '0;
      tok_path_q  <= '0;
      exit_q      <= '0;
      green_q     <= '0;
      lights_q    <= '0;
      out_valid_q <= 1'b0;
      park_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_dir_q   <= '0;
      out_path_q  <= '0;
    end else begin
      state_q     <= state_d;
      tok_dir_q   <= tok_dir_d;
      tok_path_q  <= tok_path_d;
      exit_q      <= exit_d;
      green_q     <= green_d;
      lights_q    <= lights_d;
      out_valid_q <= out_valid_d;
      park_q      <= park_d;
      busy_q      <= busy_d;
      out_dir_q   <= out_dir_d;
      out_path_q  <= out_path_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_dir_o   = out_dir_q;
  assign out_path_o  = out_path_q;
  assign nl_o        = lights_q[0];
  assign wl_o        = lights_q[1];
  assign el_o        = lights_q[2];
  assign sl_o        = lights_q[3];
  assign park_o      = park_q;
  assign busy_o      = busy_q;

`ifdef JUNCTION_STATS_EN
  logic handshake;
  assign handshake = (state_q == S_HANDOFF) && out_ready_i;

  // Saturating count of forwarded tokens per exit side.
  for (genvar k = 0; k < 4; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (handshake && out_dir_q == 2'(k) && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
    assign exit_cnt_o[k*CNT_W +: CNT_W] = cnt_q;
  end
`else
  assign exit_cnt_o = '0;
`endif

endmodule

// File: tb/tb_junction_router.sv
// Randomised self-checking bench for junction_router against a compass-angle reference model.
module tb_junction_router;

  localparam int unsigned PATH_W       = 8;
  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned GREEN_CYCLES = 8;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned CNT_MAX      = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [1:0]        in_dir_i = '0;
  logic [PATH_W-1:0] in_path_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [1:0]        out_dir_o;
  logic [PATH_W-1:0] out_path_o;
  logic              nl_o, wl_o, el_o, sl_o, park_o, busy_o;
  logic [4*CNT_W-1:0] exit_cnt_o;
  logic [3:0]        lights;

  typedef struct packed {
    logic [1:0]        dir;
    logic [PATH_W-1:0] path;
  } tok_t;

  tok_t        q[$];
  int unsigned exp_cnt [4];
  int          checks = 0;
  int          errors = 0;

  junction_router #(
    .PATH_W(PATH_W), .FIFO_DEPTH(FIFO_DEPTH), .GREEN_CYCLES(GREEN_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_dir_i(in_dir_i), .in_path_i(in_path_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_dir_o(out_dir_o), .out_path_o(out_path_o),
    .nl_o(nl_o), .wl_o(wl_o), .el_o(el_o), .sl_o(sl_o),
    .park_o(park_o), .busy_o(busy_o), .exit_cnt_o(exit_cnt_o)
  );

  assign lights = {sl_o, el_o, wl_o, nl_o};

  always #5 clk = ~clk;

  // Sides as clockwise compass angles (N=0,E=1,S=2,W=3); exit angle = arrival angle + turn code.
  function automatic logic [1:0] model_exit(input logic [1:0] dir, input logic [1:0] turn);
    int a;
    case (dir)
      2'd0:    a = 0;
      2'd1:    a = 3;
      2'd2:    a = 1;
      default: a = 2;
    endcase
    a = (a + int'(turn)) % 4;
    case (a)
      0:       return 2'd0;
      1:       return 2'd2;
      2:       return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [4*CNT_W-1:0] model_cnt();
    logic [4*CNT_W-1:0] v;
    v = '0;
`ifdef JUNCTION_STATS_EN
    for (int k = 0; k < 4; k++) v[k*CNT_W +: CNT_W] = CNT_W'(exp_cnt[k]);
`endif
    return v;
  endfunction

  task automatic bump(input logic [1:0] d);
    if (exp_cnt[d] < CNT_MAX) exp_cnt[d]++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    rst_n       = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    q.delete();
    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
  endtask

  task automatic test_reset();
    in_valid_i = 1'b0;
    rst_n      = 1'b0;
    tick();
    checks++;
    if ({in_ready_o, out_valid_o, lights, park_o, busy_o} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b vld=%b lights=%b park=%b busy=%b want 1 0 0000 0 0",
               in_ready_o, out_valid_o, lights, park_o, busy_o);
    end
    checks++;
    if ({out_dir_o, out_path_o} !== '0 || exit_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_data got dir=%b path=%h cnt=%h want 0 0 0", out_dir_o, out_path_o, exit_cnt_o);
    end
    apply_reset();
  endtask

  task automatic test_route();
    int n_green = 0, first_valid = -1, n_valid = 0, bad_light = 0;
    apply_reset();
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_dir_i    = 2'b00;
    in_path_i   = 8'b10_01_11_00;
    tick();
    in_valid_i  = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      if (sl_o) n_green++;
      if ((lights & 4'b0111) != 4'b0000) bad_light++;
      if (out_valid_o) begin
        n_valid++;
        if (first_valid < 0) begin
          first_valid = t;
          checks++;
          if (out_dir_o !== 2'b11 || out_path_o !== 8'b01_11_00_00) begin
            errors++;
            $display("FAIL route_token got dir=%b path=%b want 11 01110000", out_dir_o, out_path_o);
          end
        end
        bump(out_dir_o);
      end
      tick();
    end
    checks++;
    if (n_green != GREEN_CYCLES + 1) begin
      errors++;
      $display("FAIL route_green_len got %0d want %0d", n_green, GREEN_CYCLES + 1);
    end
    checks++;
    if (first_valid != 3 + GREEN_CYCLES || n_valid != 1) begin
      errors++;
      $display("FAIL route_latency got cycle=%0d count=%0d want %0d 1", first_valid, n_valid, 3 + GREEN_CYCLES);
    end
    checks++;
    if (bad_light != 0) begin
      errors++;
      $display("FAIL route_other_lights got %0d cycles want 0", bad_light);
    end
  endtask

  task automatic test_turns();
    tok_t       tk;
    logic [1:0] e;
    int         got;
    apply_reset();
    out_ready_i = 1'b1;
    for (int d = 0; d < 4; d++) begin
      for (int t = 1; t < 4; t++) begin
        tk.dir  = 2'(d);
        tk.path = {2'(t), 6'($urandom)};
        e       = model_exit(tk.dir, 2'(t));
        in_valid_i = 1'b1;
        in_dir_i   = tk.dir;
        in_path_i  = tk.path;
        tick();
        in_valid_i = 1'b0;
        got = 0;
        for (int k = 0; k < 40 && got == 0; k++) begin
          if (out_valid_o) got = 1;
          else tick();
        end
        checks++;
        if (got == 0 || out_dir_o !== e || lights !== (4'b0001 << e) ||
            out_path_o !== {tk.path[PATH_W-3:0], 2'b00}) begin
          errors++;
          $display("FAIL turn_d%0d_t%0d got vld=%b dir=%b lights=%b path=%h want 1 %b %b %h", d, t,
                   out_valid_o, out_dir_o, lights, out_path_o, e, 4'b0001 << e, {tk.path[PATH_W-3:0], 2'b00});
        end
        if (got != 0) bump(out_dir_o);
        tick();
      end
    end
    checks++;
    if (exit_cnt_o !== model_cnt()) begin
      errors++;
      $display("FAIL turn_counts got %h want %h", exit_cnt_o, model_cnt());
    end
  endtask

  task automatic test_park();
    logic [PATH_W-1:0] paths [2];
    int parks, park_at, lit, vld;
    paths[0] = 8'h00;
    paths[1] = 8'b00_10_01_11;
    apply_reset();
    out_ready_i = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int d = 0; d < 4; d++) begin
        in_valid_i = 1'b1;
        in_dir_i   = 2'(d);
        in_path_i  = paths[p];
        tick();
        in_valid_i = 1'b0;
        parks = 0; park_at = -1; lit = 0; vld = 0;
        for (int t = 1; t <= 8; t++) begin
          if (park_o) begin parks++; park_at = t; end
          if (lights != 4'b0000) lit++;
          if (out_valid_o) vld++;
          tick();
        end
        checks++;
        if (parks != 1 || park_at != 3 || lit != 0 || vld != 0) begin
          errors++;
          $display("FAIL park_p%0d_d%0d got pulses=%0d at=%0d lit=%0d vld=%0d want 1 3 0 0",
                   p, d, parks, park_at, lit, vld);
        end
      end
    end
    checks++;
    if (exit_cnt_o !== model_cnt()) begin
      errors++;
      $display("FAIL park_counts got %h want %h", exit_cnt_o, model_cnt());
    end
  endtask

  task automatic test_backpressure();
    tok_t              tk [6];
    int                idx = 0, got = 0;
    logic              acc;
    logic [1:0]        hold_dir;
    logic [PATH_W-1:0] hold_path;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      tk[i].dir  = 2'($urandom);
      tk[i].path = {2'($urandom_range(1, 3)), 6'($urandom)};
    end
    out_ready_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      in_valid_i = (idx < 6);
      if (idx < 6) begin in_dir_i = tk[idx].dir; in_path_i = tk[idx].path; end
      acc = in_valid_i && in_ready_o;
      tick();
      if (acc) idx++;
    end
    checks++;
    if (idx != 5 || in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_accepts got %0d rdy=%b want 5 0", idx, in_ready_o);
    end
    hold_dir  = out_dir_o;
    hold_path = out_path_o;
    tick();
    tick();
    checks++;
    if (out_valid_o !== 1'b1 || out_dir_o !== model_exit(tk[0].dir, tk[0].path[PATH_W-1 -: 2]) ||
        out_dir_o !== hold_dir || out_path_o !== hold_path) begin
      errors++;
      $display("FAIL bp_stall_hold got vld=%b dir=%b path=%h want 1 %b %h", out_valid_o, out_dir_o, out_path_o,
               model_exit(tk[0].dir, tk[0].path[PATH_W-1 -: 2]), {tk[0].path[PATH_W-3:0], 2'b00});
    end
    out_ready_i = 1'b1;
    for (int c = 0; c < 200 && got < 6; c++) begin
      if (out_valid_o) begin
        checks++;
        if (out_dir_o !== model_exit(tk[got].dir, tk[got].path[PATH_W-1 -: 2]) ||
            out_path_o !== {tk[got].path[PATH_W-3:0], 2'b00}) begin
          errors++;
          $display("FAIL bp_order_%0d got dir=%b path=%h want %b %h", got, out_dir_o, out_path_o,
                   model_exit(tk[got].dir, tk[got].path[PATH_W-1 -: 2]), {tk[got].path[PATH_W-3:0], 2'b00});
        end
        bump(out_dir_o);
        got++;
      end
      in_valid_i = (idx < 6);
      if (idx < 6) begin in_dir_i = tk[idx].dir; in_path_i = tk[idx].path; end
      acc = in_valid_i && in_ready_o;
      tick();
      if (acc) idx++;
    end
    in_valid_i = 1'b0;
    checks++;
    if (got != 6) begin
      errors++;
      $display("FAIL bp_drain got %0d tokens want 6", got);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 260;
    int   sent = 0, hs = 0, last_hs = 0;
    logic acc;
    apply_reset();
    out_ready_i = 1'b1;
    for (int c = 0; c < 3500 && hs < N; c++) begin
      if (out_valid_o) begin
        if (hs > 0) begin
          checks++;
          if (c - last_hs != GREEN_CYCLES + 3 || out_dir_o !== 2'b11) begin
            errors++;
            $display("FAIL b2b_interval_%0d got %0d dir=%b want %0d 11", hs, c - last_hs, out_dir_o, GREEN_CYCLES + 3);
          end
        end
        bump(2'b11);
        last_hs = c;
        hs++;
      end
      in_valid_i = (sent < N);
      in_dir_i   = 2'b00;
      in_path_i  = {2'b10, 6'($urandom)};
      acc = in_valid_i && in_ready_o;
      tick();
      if (acc) sent++;
      if (hs == 5 && out_valid_o == 1'b0 && c == last_hs) begin
        checks++;
        if (exit_cnt_o !== model_cnt()) begin
          errors++;
          $display("FAIL b2b_cnt_5 got %h want %h", exit_cnt_o, model_cnt());
        end
      end
    end
    in_valid_i = 1'b0;
    checks++;
    if (hs != N || exit_cnt_o !== model_cnt()) begin
      errors++;
      $display("FAIL b2b_saturate got hs=%0d cnt=%h want %0d %h", hs, exit_cnt_o, N, model_cnt());
    end
  endtask

  task automatic test_random();
    tok_t              tk, h;
    logic              prev_stall = 1'b0;
    logic [1:0]        prev_dir = '0;
    logic [PATH_W-1:0] prev_path = '0;
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      if (park_o) begin
        checks++;
        if (q.size() == 0 || q[0].path[PATH_W-1 -: 2] != 2'b00) begin
          errors++;
          $display("FAIL rnd_park cyc=%0d got park=1 want head turn 00 (queued=%0d)", c, q.size());
        end else void'(q.pop_front());
      end
      if (out_valid_o) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious cyc=%0d got out_valid=1 want 0", c);
        end else begin
          h = q[0];
          if (out_dir_o !== model_exit(h.dir, h.path[PATH_W-1 -: 2]) ||
              out_path_o !== {h.path[PATH_W-3:0], 2'b00} ||
              lights !== (4'b0001 << model_exit(h.dir, h.path[PATH_W-1 -: 2]))) begin
            errors++;
            $display("FAIL rnd_token cyc=%0d got dir=%b path=%h lights=%b want %b %h", c, out_dir_o, out_path_o,
                     lights, model_exit(h.dir, h.path[PATH_W-1 -: 2]), {h.path[PATH_W-3:0], 2'b00});
          end
        end
      end
      if (prev_stall) begin
        checks++;
        if (out_valid_o !== 1'b1 || out_dir_o !== prev_dir || out_path_o !== prev_path) begin
          errors++;
          $display("FAIL rnd_hold cyc=%0d got vld=%b dir=%b path=%h want 1 %b %h", c, out_valid_o, out_dir_o,
                   out_path_o, prev_dir, prev_path);
        end
      end
      out_ready_i = ($urandom_range(0, 3) != 0);
      in_valid_i  = (c < 1800) && ($urandom_range(0, 1) != 0);
      tk.dir      = 2'($urandom);
      tk.path     = PATH_W'($urandom);
      in_dir_i    = tk.dir;
      in_path_i   = tk.path;
      if (out_valid_o && out_ready_i && q.size() > 0) begin
        h = q.pop_front();
        bump(model_exit(h.dir, h.path[PATH_W-1 -: 2]));
      end
      if (in_valid_i && in_ready_o) q.push_back(tk);
      prev_stall = out_valid_o && !out_ready_i;
      prev_dir   = out_dir_o;
      prev_path  = out_path_o;
      tick();
    end
    in_valid_i = 1'b0;
    checks++;
    if (q.size() != 0 || busy_o !== 1'b0 || exit_cnt_o !== model_cnt()) begin
      errors++;
      $display("FAIL rnd_drain got queued=%0d busy=%b cnt=%h want 0 0 %h", q.size(), busy_o, exit_cnt_o, model_cnt());
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0, lit = 0;
    apply_reset();
    out_ready_i = 1'b0;
    in_dir_i    = 2'b00;
    in_path_i   = 8'b10_10_10_10;
    in_valid_i  = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    in_valid_i = 1'b0;
    for (int c = 0; c < 20 && lit == 0; c++) begin
      if (sl_o) lit = 1;
      else tick();
    end
    checks++;
    if (lit == 0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_setup got lit=%0d busy=%b want 1 1", lit, busy_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready_o, out_valid_o, lights, park_o, busy_o} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL rstmid_async got rdy=%b vld=%b lights=%b park=%b busy=%b want 1 0 0000 0 0",
               in_ready_o, out_valid_o, lights, park_o, busy_o);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (busy_o || out_valid_o || lights != 4'b0000) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rstmid_discard got %0d active cycles want 0", seen);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_route();
    test_turns();
    test_park();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
